verin_duty_ramp_pwm: RTL and testbench
======================================

Name: verin_duty_ramp_pwm

Overview:
Drives the actuator (vérin) power stage from the 16-bit duty value written by the CPU to the duty PIO.
- Generates a PWM output plus a direction output.
- Slew-limits duty changes once per PWM period.
- Forces a ramp to zero before any direction reversal.
- Sits between the duty/direction PIO outputs and the H-bridge pins; one instance per actuator.

Parameters:
CNT_W, 16, width of duty, period and step values
PRESCALE, 1, clk cycles per PWM count tick (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run request; 0 = immediate stop
duty_target  in  CNT_W  requested duty in ticks (duty PIO out_port)
dir_target  in  1  requested direction
period  in  CNT_W  PWM period in ticks
ramp_step  in  CNT_W  max duty change per period; 0 = no ramp
pwm_out  out  1  PWM to power stage
dir_out  out  1  applied direction
duty_cur  out  CNT_W  currently applied duty
at_target  out  1  applied duty/direction equal request
period_tick  out  1  one-clk pulse at each period start

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state changes occur on rising clk edges.
- Reset values: state IDLE; duty_cur, cnt, prescaler all 0; pwm_out, dir_out, at_target, period_tick all 0; period_lat = 2. Reset mid-operation gives the same values at the next edge.
- Period handling:
  - period_eff = max(period, 2).
  - period is latched into period_lat only at a boundary; a mid-period change takes effect at the next boundary.
- Counting:
  - tick asserts every PRESCALE clks while not IDLE.
  - cnt advances on tick.
  - Boundary = tick and cnt == period_lat-1; cnt then wraps to 0.
- Target clamp: t_eff = min(duty_target, period_lat_new), where period_lat_new is the value latched at that boundary.
- Duty update at a boundary (RUN):
  - ramp_step == 0: duty_cur := t_eff.
  - duty_cur < t_eff: duty_cur := min(duty_cur+ramp_step, t_eff), computed in CNT_W+1 bits with no wrap.
  - duty_cur > t_eff: duty_cur := max(duty_cur-ramp_step, t_eff), no underflow.
- PWM output:
  - pwm_out registered = (state != IDLE) and (cnt < duty_cur); 1 clk latency from cnt.
  - duty_cur >= period_lat gives a constant high output.
  - duty_cur == 0 gives a constant low output.
- period_tick: high for exactly one clk in the cycle cnt becomes 0 (boundary, or the IDLE->RUN entry).
- State machine:
  - IDLE: enable=1 -> RUN. The entry counts as a boundary:
    - period latched, cnt=0;
    - dir_out := dir_target;
    - duty_cur := ramp from 0.
  - RUN:
    - dir_target != dir_out and duty_cur != 0 -> REVERSE (next clk).
    - dir_target != dir_out and duty_cur == 0: at the next boundary, dir_out := dir_target and the normal ramp-up applies in the same update.
  - REVERSE: effective target is 0 and ramping is as above. At the boundary where the new duty_cur is 0:
    - dir_out := dir_target;
    - go to RUN;
    - the following period runs at 0 duty (guaranteed one-period dead time).
  - If dir_target returns to dir_out during REVERSE, the block still completes the ramp to 0 (no abort).
- Any state, enable=0: next edge state IDLE, duty_cur=0, cnt=0, pwm_out=0. There is no ramp (emergency stop). dir_out is held.
- at_target = (state==RUN) and duty_cur==t_eff and dir_out==dir_target. Registered, updated every clk.
- Simultaneous events:
  - reset has priority over enable=0.
  - enable=0 has priority over a boundary.
  - A direction change and a duty change at the same boundary are handled by the REVERSE rule.

Decomposition:
- Package verin_pkg holds:
  - state enum {IDLE, RUN, REVERSE};
  - PERIOD_MIN = 2;
  - default CNT_W.
- Sub-module verin_pwm_counter holds the prescaler, period latch, cnt, boundary strobe and period_tick.
- The top level keeps the FSM, ramp arithmetic and pwm compare.

Test Plan:
1. PRESCALE=1, period=10, ramp_step=3, duty_target=8, dir=0, raise enable -> duty_cur 3,6,8 over successive periods; pwm_out high 3/6/8 of 10 clks; at_target=1 from third period on.
2. duty_target=20, period=10, ramp_step=0 -> duty_cur=10 after first boundary, pwm_out constant 1, at_target=1.
3. From steady duty 8 dir 0, set dir_target=1, ramp_step=3 -> duty_cur 5,2,0 with dir_out=0; dir_out=1 at the boundary where duty_cur becomes 0; one period at 0 duty, then 3,6,8.
4. Drop enable mid-period (cnt=4, duty 8) -> next clk pwm_out=0, duty_cur=0, cnt=0, at_target=0; dir_out unchanged.
5. Steady duty 8 with period=10 -> write period=4 at cnt=2 -> current period completes 10 clks; next period is 4 clks with duty_cur clamped to 4 (ramp_step=0); period_tick spacing 10 then 4.
6. Assert reset for one clk mid-RUN (duty 6, dir 1) -> all outputs 0, state IDLE at next edge; with enable still 1, RUN re-entered and ramp restarts from 0.

Source files
------------

// File: rtl/verin_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : verin_pkg
//  Description : Shared types and constants for the actuator (verin) duty
//                ramp PWM driver: controller state encoding, the minimum
//                usable PWM period and the default counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package verin_pkg;

    // Default width of duty, period and step values.
    localparam int CNT_W_DEFAULT = 16;

    // Shortest period that still leaves room for both a high and a low phase.
    localparam int PERIOD_MIN = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        REVERSE = 2'd2
    } verin_state_e;

endpackage
`default_nettype wire

// File: rtl/verin_pwm_counter.sv
`default_nettype none
// ============================================================================
//  Module      : verin_pwm_counter
//  Description : PWM time base. Prescales clk into count ticks, counts ticks
//                within the latched period, flags the last tick of a period
//                (boundary) and pulses period_tick when the count restarts.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                i_start            - run entry; restarts the period now
//                i_stop             - immediate stop; clears the count
//                i_active           - controller is not idle
//                i_period           - requested period in ticks
//                o_period_new       - period that would be latched now
//                o_period_lat       - period of the running PWM cycle
//                o_cnt              - tick position inside the period
//                o_boundary         - last tick of the period (combinational)
//                o_period_tick      - one-clk pulse when o_cnt restarts at 0
//  Revision    : 1.0 - initial release
// ============================================================================
module verin_pwm_counter
    import verin_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_active,
    input  logic [CNT_W-1:0] i_period,
    output logic [CNT_W-1:0] o_period_new,
    output logic [CNT_W-1:0] o_period_lat,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_boundary,
    output logic             o_period_tick
);

    localparam logic [CNT_W-1:0] c_PERIOD_MIN = CNT_W'(PERIOD_MIN);

    logic             w_tick;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period_lat;
    logic             r_period_tick;

    generate
        if (PRESCALE <= 1) begin : g_presc_none
            assign w_tick = i_active;
        end else begin : g_presc_div
            localparam int c_PRESC_W = $clog2(PRESCALE);
            logic [c_PRESC_W-1:0] r_presc;

            assign w_tick = i_active && (r_presc == c_PRESC_W'(PRESCALE - 1));

            // Held at zero while idle so the first tick after entry comes a
            // full PRESCALE clks later.
            always_ff @(posedge clk) begin
                if (rst || i_stop || !i_active) begin
                    r_presc <= '0;
                end else if (w_tick) begin
                    r_presc <= '0;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    endgenerate

    assign o_period_new = (i_period < c_PERIOD_MIN) ? c_PERIOD_MIN : i_period;
    assign o_boundary   = w_tick && (r_cnt == r_period_lat - CNT_W'(1));

    // The period only changes together with the count restart, so r_cnt can
    // never run past r_period_lat-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_period_lat  <= c_PERIOD_MIN;
            r_period_tick <= 1'b0;
        end else if (i_stop) begin
            r_cnt         <= '0;
            r_period_tick <= 1'b0;
        end else if (i_start || o_boundary) begin
            r_cnt         <= '0;
            r_period_lat  <= o_period_new;
            r_period_tick <= 1'b1;
        end else begin
            r_period_tick <= 1'b0;
            if (w_tick) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_period_lat  = r_period_lat;
    assign o_cnt         = r_cnt;
    assign o_period_tick = r_period_tick;

endmodule
`default_nettype wire

// File: rtl/verin_duty_ramp_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : verin_duty_ramp_pwm
//  Description : Actuator power-stage driver. Produces PWM plus direction from
//                the CPU duty/direction request, slew-limits duty once per PWM
//                period and ramps to zero (plus one dead period) before any
//                direction reversal. enable=0 is an immediate stop.
//  Ports       : clk, reset   - clock, synchronous active-high reset
//                enable       - run request, 0 stops at the next edge
//                duty_target  - requested duty in ticks
//                dir_target   - requested direction
//                period       - PWM period in ticks (values below 2 use 2)
//                ramp_step    - max duty change per period, 0 = jump
//                pwm_out      - PWM to the H-bridge
//                dir_out      - applied direction
//                duty_cur     - currently applied duty
//                at_target    - applied duty/direction match the request
//                period_tick  - one-clk pulse at each period start
//  Revision    : 1.0 - initial release
// ============================================================================
module verin_duty_ramp_pwm
    import verin_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] duty_target,
    input  logic             dir_target,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] ramp_step,
    output logic             pwm_out,
    output logic             dir_out,
    output logic [CNT_W-1:0] duty_cur,
    output logic             at_target,
    output logic             period_tick
);

    verin_state_e     r_state, w_state_nxt;
    logic [CNT_W-1:0] r_duty, w_duty_nxt;
    logic             r_dir, w_dir_nxt;
    logic             r_pwm, w_pwm_nxt;
    logic             r_at, w_at_nxt;

    logic [CNT_W-1:0] w_cnt, w_period_lat, w_period_new, w_period_lat_nxt;
    logic             w_boundary, w_start, w_active, w_reversing;
    logic [CNT_W-1:0] w_t_eff, w_t_hold, w_ramp_tgt, w_duty_ramped;

    // One slew-limited step from cur toward tgt; the upward sum carries an
    // extra bit so a large step near full scale cannot wrap.
    function automatic logic [CNT_W-1:0] f_ramp(input logic [CNT_W-1:0] cur,
                                                 input logic [CNT_W-1:0] tgt,
                                                 input logic [CNT_W-1:0] step);
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} + {1'b0, step};
        if (step == '0)                return tgt;
        else if (cur < tgt)            return (sum > {1'b0, tgt}) ? tgt : sum[CNT_W-1:0];
        else if ((cur - tgt) > step)   return cur - step;
        else                           return tgt;
    endfunction

    assign w_start  = (r_state == IDLE) && enable;
    assign w_active = (r_state != IDLE);

    verin_pwm_counter #(
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE)
    ) u_counter (
        .clk           (clk),
        .rst           (reset),
        .i_start       (w_start),
        .i_stop        (!enable),
        .i_active      (w_active),
        .i_period      (period),
        .o_period_new  (w_period_new),
        .o_period_lat  (w_period_lat),
        .o_cnt         (w_cnt),
        .o_boundary    (w_boundary),
        .o_period_tick (period_tick)
    );

    // Target clamped against the period that takes effect at this update.
    assign w_t_eff = (duty_target < w_period_new) ? duty_target : w_period_new;

    // A reversal is pending either once committed (REVERSE) or when the
    // request flips while power is still applied; both aim the ramp at 0.
    assign w_reversing   = (r_state == REVERSE) ||
                           ((r_state == RUN) && (dir_target != r_dir) && (r_duty != '0));
    assign w_ramp_tgt    = w_reversing ? '0 : w_t_eff;
    assign w_duty_ramped = f_ramp(r_duty, w_ramp_tgt, ramp_step);

    assign w_period_lat_nxt = (w_start || w_boundary) ? w_period_new : w_period_lat;
    assign w_t_hold = (duty_target < w_period_lat_nxt) ? duty_target : w_period_lat_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_dir_nxt   = r_dir;
        if (!enable) begin
            w_state_nxt = IDLE;
            w_duty_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Entry behaves as a boundary; r_duty is 0 here.
                    w_state_nxt = RUN;
                    w_duty_nxt  = w_duty_ramped;
                    w_dir_nxt   = dir_target;
                end
                RUN, REVERSE: begin
                    if (w_boundary) begin
                        w_duty_nxt = w_duty_ramped;
                        if (w_reversing && (w_duty_ramped != '0)) begin
                            w_state_nxt = REVERSE;
                        end else begin
                            // Duty is 0 for the coming period: safe to switch
                            // direction. After a reversal this period is the
                            // dead time, the ramp-up starts next boundary.
                            w_state_nxt = RUN;
                            w_dir_nxt   = dir_target;
                        end
                    end else begin
                        w_state_nxt = w_reversing ? REVERSE : RUN;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_duty_nxt  = '0;
                end
            endcase
        end
        w_at_nxt  = (w_state_nxt == RUN) && (w_duty_nxt == w_t_hold) &&
                    (w_dir_nxt == dir_target);
        w_pwm_nxt = enable && w_active && (w_cnt < r_duty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_duty  <= '0;
            r_dir   <= 1'b0;
            r_pwm   <= 1'b0;
            r_at    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_dir   <= w_dir_nxt;
            r_pwm   <= w_pwm_nxt;
            r_at    <= w_at_nxt;
        end
    end

    assign pwm_out   = r_pwm;
    assign dir_out   = r_dir;
    assign duty_cur  = r_duty;
    assign at_target = r_at;

endmodule
`default_nettype wire

// File: tb/tb_verin_duty_ramp_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_verin_duty_ramp_pwm
//  Description : Self-checking bench for verin_duty_ramp_pwm. A behavioural
//                model tracks every clk; a table of whole-period records and
//                hand sequences check ramp, reversal, period change, stop and
//                reset against hand-derived values; random traffic follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_verin_duty_ramp_pwm;

    localparam int CNT_W    = 16;
    localparam int PRESCALE = 1;
    localparam int T        = 10;

    logic             clk         = 1'b0;
    logic             reset       = 1'b1;
    logic             enable      = 1'b0;
    logic             dir_target  = 1'b0;
    logic [CNT_W-1:0] duty_target = '0;
    logic [CNT_W-1:0] period      = CNT_W'(10);
    logic [CNT_W-1:0] ramp_step   = '0;
    logic             pwm_out, dir_out, at_target, period_tick;
    logic [CNT_W-1:0] duty_cur;

    always #(T/2) clk = ~clk;

    verin_duty_ramp_pwm #(
        .CNT_W    (CNT_W),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .duty_target (duty_target),
        .dir_target  (dir_target),
        .period      (period),
        .ramp_step   (ramp_step),
        .pwm_out     (pwm_out),
        .dir_out     (dir_out),
        .duty_cur    (duty_cur),
        .at_target   (at_target),
        .period_tick (period_tick)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    // mode: 0 idle, 1 running, 2 ramping down for a reversal
    int m_mode = 0, m_duty = 0, m_dir = 0, m_cnt = 0, m_plat = 2;
    int m_presc = 0, m_pwm = 0, m_at = 0, m_ptick = 0;

    function automatic int f_min(input int a, input int b); return (a < b) ? a : b; endfunction
    function automatic int f_max(input int a, input int b); return (a > b) ? a : b; endfunction
    function automatic int f_step(input int cur, input int tgt, input int step);
        if (step == 0)  return tgt;
        if (cur < tgt)  return f_min(cur + step, tgt);
        return f_max(cur - step, tgt);
    endfunction

    task automatic model_step();
        int pwm_n, pe, tick, bnd, rev, tgt;
        if (reset) begin
            m_mode = 0; m_duty = 0; m_dir = 0; m_cnt = 0; m_plat = 2;
            m_presc = 0; m_pwm = 0; m_at = 0; m_ptick = 0;
            return;
        end
        if (!enable) begin
            m_mode = 0; m_duty = 0; m_cnt = 0; m_presc = 0;
            m_pwm = 0; m_at = 0; m_ptick = 0;
            return;
        end
        pwm_n = (m_mode != 0 && m_cnt < m_duty) ? 1 : 0;
        pe    = f_max(int'(period), 2);
        if (m_mode == 0) begin
            m_plat = pe; m_cnt = 0; m_presc = 0; m_ptick = 1;
            m_dir  = int'(dir_target);
            m_duty = f_step(0, f_min(int'(duty_target), pe), int'(ramp_step));
            m_mode = 1;
        end else begin
            tick    = (m_presc == PRESCALE - 1) ? 1 : 0;
            m_presc = tick ? 0 : m_presc + 1;
            bnd     = (tick && m_cnt == m_plat - 1) ? 1 : 0;
            rev     = (m_mode == 2 || (m_dir != int'(dir_target) && m_duty != 0)) ? 1 : 0;
            if (bnd) begin
                m_plat  = pe; m_cnt = 0; m_ptick = 1;
                tgt     = rev ? 0 : f_min(int'(duty_target), pe);
                m_duty  = f_step(m_duty, tgt, int'(ramp_step));
                if (rev && m_duty != 0) m_mode = 2;
                else begin m_mode = 1; m_dir = int'(dir_target); end
            end else begin
                m_ptick = 0;
                if (tick) m_cnt = m_cnt + 1;
                m_mode = rev ? 2 : 1;
            end
        end
        m_pwm = pwm_n;
        m_at  = (m_mode == 1 && m_duty == f_min(int'(duty_target), m_plat) &&
                 m_dir == int'(dir_target)) ? 1 : 0;
    endtask

    always @(posedge clk) model_step();

    bit chk_on = 1'b0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_duty", 32'(duty_cur),    32'(m_duty));
            chk("model_dir",  32'(dir_out),     32'(m_dir));
            chk("model_pwm",  32'(pwm_out),     32'(m_pwm));
            chk("model_at",   32'(at_target),   32'(m_at));
            chk("model_tick", 32'(period_tick), 32'(m_ptick));
        end
    end

    // ---------------- period-level vector table ----------------
    typedef struct {
        bit dir; int per; int step; int tgt; int apply_at;
        int e_duty; int e_dir; int e_at; int e_highs; int e_len;
    } vec_t;
    vec_t tv[16];

    task automatic apply_vec(input vec_t v);
        dir_target  = v.dir;
        period      = CNT_W'(v.per);
        ramp_step   = CNT_W'(v.step);
        duty_target = CNT_W'(v.tgt);
    endtask

    task automatic wait_ptick(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (period_tick !== 1'b1 && n < 300);
        chk(name, 32'(period_tick), 32'd1);
    endtask

    initial begin
        #(T * 40000);
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    int highs, len;

    initial begin
        //             dir per st tgt at   duty dir at highs len
        tv[0]  = '{1'b0, 10, 3,  8, 0,   3, 0, 0,  3, 10};  // ramp up 3,6,8
        tv[1]  = '{1'b0, 10, 3,  8, 0,   6, 0, 0,  6, 10};
        tv[2]  = '{1'b0, 10, 3,  8, 0,   8, 0, 1,  8, 10};
        tv[3]  = '{1'b1, 10, 3,  8, 0,   8, 0, 1,  8, 10};  // reversal request
        tv[4]  = '{1'b1, 10, 3,  8, 0,   5, 0, 0,  5, 10};
        tv[5]  = '{1'b1, 10, 3,  8, 0,   2, 0, 0,  2, 10};
        tv[6]  = '{1'b1, 10, 3,  8, 0,   0, 1, 0,  0, 10};  // dead period
        tv[7]  = '{1'b1, 10, 3,  8, 0,   3, 1, 0,  3, 10};
        tv[8]  = '{1'b1, 10, 3,  8, 0,   6, 1, 0,  6, 10};
        tv[9]  = '{1'b1, 10, 3,  8, 0,   8, 1, 1,  8, 10};
        tv[10] = '{1'b1,  4, 0,  8, 2,   8, 1, 1,  8, 10};  // period change mid-period
        tv[11] = '{1'b1,  4, 0,  8, 0,   4, 1, 1,  4,  4};  // clamped, constant high
        tv[12] = '{1'b1, 10, 0, 20, 0,   4, 1, 1,  4,  4};
        tv[13] = '{1'b1, 10, 0, 20, 0,  10, 1, 1, 10, 10};  // target above period
        tv[14] = '{1'b1,  1, 0, 20, 0,  10, 1, 1, 10, 10};  // period below minimum
        tv[15] = '{1'b1,  1, 0, 20, 0,   2, 1, 1,  2,  2};

        reset = 1'b1; enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_duty", 32'(duty_cur),    32'd0);
        chk("rst_pwm",  32'(pwm_out),     32'd0);
        chk("rst_dir",  32'(dir_out),     32'd0);
        chk("rst_at",   32'(at_target),   32'd0);
        chk("rst_tick", 32'(period_tick), 32'd0);
        reset  = 1'b0;
        chk_on = 1'b1;

        apply_vec(tv[0]);
        enable = 1'b1;
        wait_ptick("entry_tick");

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("v%0d_duty", i), 32'(duty_cur),  32'(tv[i].e_duty));
            chk($sformatf("v%0d_dir", i),  32'(dir_out),   32'(tv[i].e_dir));
            chk($sformatf("v%0d_at", i),   32'(at_target), 32'(tv[i].e_at));
            if (tv[i].apply_at == 0) apply_vec(tv[i]);
            highs = 0; len = 0;
            do begin
                @(negedge clk);
                len++;
                if (pwm_out === 1'b1) highs++;
                if (len == tv[i].apply_at) apply_vec(tv[i]);
            end while (period_tick !== 1'b1 && len < 300);
            chk($sformatf("v%0d_highs", i), 32'(highs), 32'(tv[i].e_highs));
            chk($sformatf("v%0d_len", i),   32'(len),   32'(tv[i].e_len));
        end

        // Emergency stop at cnt=4 with duty 8, then restart.
        period = CNT_W'(10); ramp_step = '0; duty_target = CNT_W'(8); dir_target = 1'b1;
        wait_ptick("stop_pre_tick");
        chk("stop_pre_duty", 32'(duty_cur), 32'd8);
        repeat (4) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("stop_pwm",  32'(pwm_out),     32'd0);
        chk("stop_duty", 32'(duty_cur),    32'd0);
        chk("stop_at",   32'(at_target),   32'd0);
        chk("stop_dir",  32'(dir_out),     32'd1);
        chk("stop_tick", 32'(period_tick), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("restart_tick", 32'(period_tick), 32'd1);
        chk("restart_duty", 32'(duty_cur),    32'd8);
        chk("restart_at",   32'(at_target),   32'd1);

        // Reset pulse mid-run at duty 6, enable held high.
        ramp_step = CNT_W'(3);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_ptick("rr_entry_tick");
        chk("rr_duty3", 32'(duty_cur), 32'd3);
        wait_ptick("rr_second_tick");
        chk("rr_duty6", 32'(duty_cur), 32'd6);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rr_duty0", 32'(duty_cur),    32'd0);
        chk("rr_dir0",  32'(dir_out),     32'd0);
        chk("rr_pwm0",  32'(pwm_out),     32'd0);
        chk("rr_at0",   32'(at_target),   32'd0);
        chk("rr_tick0", 32'(period_tick), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rr_re_tick", 32'(period_tick), 32'd1);
        chk("rr_re_duty", 32'(duty_cur),    32'd3);
        chk("rr_re_dir",  32'(dir_out),     32'd1);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            if (!enable) enable = ($urandom_range(0, 3) == 0);
            else         enable = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 15) == 0)
                duty_target = ($urandom_range(0, 3) == 0) ? 16'hFFFF : CNT_W'($urandom_range(0, 14));
            if ($urandom_range(0, 15) == 0)
                period = CNT_W'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0)
                ramp_step = ($urandom_range(0, 5) == 0) ? CNT_W'(16'hFFFF - $urandom_range(0, 1))
                                                        : CNT_W'($urandom_range(0, 4));
            if ($urandom_range(0, 31) == 0) dir_target = ~dir_target;
        end
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
